// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared fetch-stage state encoding and fixed fetch addresses
package cpu_defs;
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fs_state_t;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_VEC  = 32'hbfc00380;
endpackage

// File: rtl/fetch_redirect_arb.sv
// fetch_redirect_arb: priority mux of redirect sources (exception > eret > branch)
module fetch_redirect_arb #(
    parameter logic [31:0] EXC_VEC = cpu_defs::EXC_VEC
) (
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic        br_valid,
    input  logic [31:0] epc,
    input  logic [31:0] br_target,
    output logic        redir,
    output logic [31:0] redir_target
);
    // pick the highest-priority redirect target; redir flags any source
    always_comb begin
        redir        = exc_valid | eret_valid | br_valid;
        redir_target = exc_valid ? EXC_VEC : eret_valid ? epc : br_target;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC owner, single-outstanding instruction port sequencer and decode buffer
module fetch_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter logic [31:0] EXC_VEC  = cpu_defs::EXC_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        id_allowin,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);
    fs_state_t   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        discard_q, discard_d;
    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic [31:0] fs_inst_q, fs_inst_d;
    logic        redir;
    logic [31:0] redir_target;
    logic        addr_hs;

    fetch_redirect_arb #(.EXC_VEC(EXC_VEC)) u_arb (
        .exc_valid    (exc_valid),
        .eret_valid   (eret_valid),
        .br_valid     (br_valid),
        .epc          (epc),
        .br_target    (br_target),
        .redir        (redir),
        .redir_target (redir_target)
    );

    assign inst_req  = (state_q == FS_REQ) & rst;
    assign inst_addr = fetch_pc_q;
    assign addr_hs   = inst_req & inst_addr_ok;
    assign fs_valid  = fs_valid_q;
    assign fs_pc     = fs_pc_q;
    assign fs_inst   = fs_inst_q;

    // next-state: request/wait/hold sequencing with redirects overriding the PC and killing stale data
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        fs_valid_d = fs_valid_q;
        fs_pc_d    = fs_pc_q;
        fs_inst_d  = fs_inst_q;
        case (state_q)
            FS_REQ: begin
                fetch_pc_d = redir ? redir_target : fetch_pc_q;
                if (addr_hs) begin
                    state_d   = FS_WAIT;
                    discard_d = redir;
                end
            end
            FS_WAIT: begin
                fetch_pc_d = redir ? redir_target : fetch_pc_q;
                if (inst_data_ok && !discard_q && !redir) begin
                    fs_inst_d  = inst_rdata;
                    fs_pc_d    = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    fs_valid_d = 1'b1;
                    state_d    = FS_HOLD;
                end else if (inst_data_ok) begin
                    discard_d = 1'b0;
                    state_d   = FS_REQ;
                end else if (redir) begin
                    discard_d = 1'b1;
                end
            end
            FS_HOLD: begin
                if (redir || id_allowin) begin
                    fs_valid_d = 1'b0;
                    fetch_pc_d = redir ? redir_target : fetch_pc_q;
                    state_d    = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FS_REQ;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
            fs_valid_q <= 1'b0;
            fs_pc_q    <= 32'd0;
            fs_inst_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            fs_valid_q <= fs_valid_d;
            fs_pc_q    <= fs_pc_d;
            fs_inst_q  <= fs_inst_d;
        end
    end
endmodule
